i2s_transmitter: RTL
====================

# i2s_transmitter

Serializes stereo PCM samples onto the I2S data line for the pedal's output DAC. The block runs in the `mclk` domain and consumes the `sclk`/`lrclk` pair produced by the I2S clock divider: 32 sclk cycles per channel slot and 64 per stereo frame. It accepts one left/right pair per frame from the DSP chain over a valid/ready handshake, buffers one pair, and shifts it out MSB-first in standard I2S format with a one-bit delay.

## Interface
- `DATA_WIDTH`, 24: sample width in bits; legal range 1..31, since the slot is fixed at 32 bits.
- `mclk`  in  1  master clock; all logic is clocked on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `sclk`  in  1  serial clock from the divider, registered in the `mclk` domain (no synchronizer needed).
- `lrclk`  in  1  word clock from the divider; 0 = left, 1 = right. It toggles only in the same `mclk` cycle that `sclk` falls.
- `s_left`  in  DATA_WIDTH  left sample, two's complement.
- `s_right`  in  DATA_WIDTH  right sample.
- `s_valid`  in  1  sample pair valid.
- `s_ready`  out  1  hold buffer empty; a transfer occurs when `s_valid & s_ready`.
- `sdata`  out  1  I2S serial data to the DAC.
- `underrun`  out  1  one-cycle pulse: a frame started with no sample pair buffered.

## Operation
- **Edge detection:** `sclk_d` and `lrclk_d` hold the previous-cycle values.
  - `fall = sclk_d & ~sclk`.
  - `lr_edge = fall & (lrclk != lrclk_d)`.
  - `left_start = lr_edge & ~lrclk`.
  - `right_start = lr_edge & lrclk`.
- **Hold buffer:** one stereo pair (`hold_l`, `hold_r`, `hold_full`).
  - On a transfer: capture both samples and set `hold_full`.
  - `s_ready` is 0 while `rst_n` is sampled low; otherwise `s_ready == !hold_full`.
- **States:** UNSYNCED and RUN.
  - UNSYNCED is the reset state. `sdata` is held at 0 and `right_start` is ignored. A `left_start` enters RUN and performs the frame load below.
  - RUN continues until reset.
- **Frame load (`left_start`):**
  - If `hold_full`: `shreg <= hold_l`, `pend_r <= hold_r`, clear `hold_full`.
  - Else: `shreg <= 0`, `pend_r <= 0`, pulse `underrun`.
  - In both cases `bit_idx <= 0` and `sdata <= 0` (the delay slot, i.e. the last bit of the previous slot).
- **Right load (`right_start`, RUN only):** `shreg <= pend_r`, `bit_idx <= 0`, `sdata <= 0`.
- **Shifting (`fall & ~lr_edge`, RUN):**
  - If `bit_idx < DATA_WIDTH`: `sdata <= shreg[DATA_WIDTH-1]`, shift `shreg` left by 1, increment `bit_idx`.
  - Otherwise `sdata <= 0`, and `bit_idx` saturates at `DATA_WIDTH`.
- **Resulting slot layout per channel:**
  - Bit 0 (the delay slot) = 0.
  - Bits 1..DATA_WIDTH = sample, MSB first.
  - Remaining bits = 0.
- **Simultaneous transfer and `left_start` with the buffer empty:** there is no bypass. The frame outputs zeros, `underrun` pulses, and the accepted pair is transmitted in the following frame.
- **Reset mid-frame:** all state is cleared and the block returns to UNSYNCED. Output is 0 until the next `left_start`; any buffered pair is discarded.

## Timing
- **Reset values:** `sdata` = 0, `underrun` = 0, `s_ready` = 0. Internal state: `hold_full` = 0, UNSYNCED.
- **Ready after reset:** `s_ready` = 1 in the first cycle after `rst_n` is sampled high.
- **`sdata` latency:** updates on the `mclk` edge one cycle after `sclk` is observed falling. With the divider's 4-mclk half period, `sdata` is stable 3 `mclk` cycles before the next rising `sclk`, where the DAC samples it.
- **`underrun`:** high for exactly the one `mclk` cycle in which the delay-slot 0 for that `left_start` is driven.
- **`s_ready` recovery:** drops the cycle after a transfer and rises the cycle after the `left_start` that consumes the buffer.
- **Throughput:** at most one pair is consumed per frame (64 sclk cycles, i.e. 512 `mclk` cycles).

## Test plan
- **Reset:** hold `rst_n` low for 5 cycles while the divider runs. Expect `sdata` = 0, `s_ready` = 0, `underrun` = 0. Expect `s_ready` = 1 one cycle after release, and `sdata` = 0 until the first `lrclk` fall.
- **Basic frame:** push left = 24'hA5A5A5, right = 24'h5A5A5A before a `left_start`. Capture `sdata` on rising `sclk`. Left slot bits 1..24 = A5A5A5 MSB-first and right slot bits 1..24 = 5A5A5A; slot bit 0 and bits 25..31 = 0 in both slots; `underrun` never asserts.
- **Underrun:** offer no data across one frame. Expect a single 1-cycle `underrun` pulse at the `lrclk` fall, and all 64 captured bits = 0.
- **Back-pressure:** drive `s_valid` = 1 with pairs P1, then P2 (P1 = 24'h123456/24'h654321, P2 = 24'h800001/24'h7FFFFF).
  - P1 is accepted and `s_ready` drops.
  - P2 is stalled until the cycle after `left_start`, then accepted.
  - Frame N carries P1 and frame N+1 carries P2.
- **Mid-frame reset:** assert `rst_n` low at right-slot bit 10. Expect `sdata` = 0 immediately and through the next right slot, then normal output resuming at the following `left_start` with a fresh pair.
- **Width parameter:** with `DATA_WIDTH` = 16, send left = 16'h8001, right = 16'h0000. Left slot bit 1 = 1, bit 16 = 1, all other left bits = 0, and the right slot is all 0.

Source files
------------

// File: rtl/i2s_transmitter.sv
// I2S transmitter: buffers one stereo pair from the DSP chain and shifts it out
// MSB-first with the standard one-bit delay, timed by the divider's sclk/lrclk.
module i2s_transmitter #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  mclk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  lrclk,
    input  logic [DATA_WIDTH-1:0] s_left,
    input  logic [DATA_WIDTH-1:0] s_right,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  sdata,
    output logic                  underrun
);
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH);

    typedef enum logic {UNSYNCED, RUN} state_t;
    state_t state, state_nxt;

    logic sclk_d, lrclk_d;
    logic fall, lr_edge, left_start, right_start;
    logic ready_en, hold_full, xfer;
    logic do_load, do_right, do_shift;
    logic [DATA_WIDTH-1:0] hold_l, hold_r, shreg, pend_r;
    logic [IDX_W-1:0] bit_idx;

    assign fall        = sclk_d & ~sclk;
    assign lr_edge     = fall & (lrclk != lrclk_d);
    assign left_start  = lr_edge & ~lrclk;
    assign right_start = lr_edge & lrclk;

    // ready_en keeps s_ready low while reset is being sampled
    assign s_ready = ready_en & ~hold_full;
    assign xfer    = s_valid & s_ready;

    always_ff @(posedge mclk) begin
        if (!rst_n) state <= UNSYNCED;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == UNSYNCED && left_start) state_nxt = RUN;
    end

    // A frame load is honoured in both states; the first one is what syncs us.
    always_comb begin
        do_load  = left_start;
        do_right = 1'b0;
        do_shift = 1'b0;
        if (state == RUN) begin
            do_right = right_start;
            do_shift = fall & ~lr_edge;
        end
    end

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            sclk_d    <= 1'b0;
            lrclk_d   <= 1'b0;
            ready_en  <= 1'b0;
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
            shreg     <= '0;
            pend_r    <= '0;
            bit_idx   <= '0;
            sdata     <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            sclk_d   <= sclk;
            lrclk_d  <= lrclk;
            ready_en <= 1'b1;
            underrun <= 1'b0;

            if (xfer) begin
                hold_l <= s_left;
                hold_r <= s_right;
            end

            // No bypass: a pair arriving with the load lands in the buffer.
            if (xfer)         hold_full <= 1'b1;
            else if (do_load) hold_full <= 1'b0;

            if (do_load) begin
                if (hold_full) begin
                    shreg  <= hold_l;
                    pend_r <= hold_r;
                end else begin
                    shreg    <= '0;
                    pend_r   <= '0;
                    underrun <= 1'b1;
                end
                bit_idx <= '0;
                sdata   <= 1'b0;
            end else if (do_right) begin
                shreg   <= pend_r;
                bit_idx <= '0;
                sdata   <= 1'b0;
            end else if (do_shift) begin
                if (bit_idx < LAST_IDX) begin
                    sdata   <= shreg[DATA_WIDTH-1];
                    shreg   <= shreg << 1;
                    bit_idx <= bit_idx + IDX_W'(1);
                end else begin
                    sdata <= 1'b0;
                end
            end
        end
    end
endmodule
